hamming_sphere_generator: RTL
=============================

Name: hamming_sphere_generator

Overview:
- Inverse of the Hamming distance block. Given a base word and a distance D, it emits, one per handshake, every word at exactly Hamming distance D from the base.
- Each output is formed as the base XOR a mask with exactly D bits set. Masks are enumerated in strictly increasing numeric order.
- Used for error-pattern injection and for exhaustive near-neighbour search in test and correction datapaths.
- Ready/valid on both input and output.

Parameters:
- WORD_WIDTH, 8, width of base word, masks and output words; must be >= 1.
- DIST_WIDTH, WORD_WIDTH, width of the distance input (matches the distance output width of the Hamming distance block).

Ports:
- clock  input  1  rising-edge clock.
- clear_n  input  1  asynchronous active-low reset.
- base_valid  input  1  base_word and base_distance are valid.
- base_ready  output  1  block is idle and accepts a new request.
- base_word  input  WORD_WIDTH  centre word of the sphere.
- base_distance  input  DIST_WIDTH  required distance D (unsigned).
- word_valid  output  1  word_out, word_mask and word_last are valid.
- word_ready  input  1  consumer accepts the current output.
- word_out  output  WORD_WIDTH  base_word XOR word_mask.
- word_mask  output  WORD_WIDTH  current mask, exactly D ones.
- word_last  output  1  current output is the final one of the sphere.
- distance_error  output  1  one-cycle pulse: request rejected because D > WORD_WIDTH.

Behaviour:
- Reset: clear_n low asynchronously forces the following, effective immediately, including mid-sphere. Any in-flight enumeration is abandoned with no further outputs.
  - state IDLE
  - base_ready=1
  - word_valid=0, word_out=0, word_mask=0, word_last=0
  - distance_error=0
  - internal base and mask registers = 0
- States IDLE, RUN. All outputs are registered except base_ready, which equals (state==IDLE).
- IDLE, base_valid&base_ready at edge N, D <= WORD_WIDTH:
  - latch base_word.
  - mask = (2^D)-1.
  - word_last = 1 if mask equals the D ones left-justified (top D bits set); always true for D=0 and D=WORD_WIDTH.
  - go to RUN; word_valid=1 from cycle N+1. First-output latency is 1 cycle.
- IDLE, accepted with D > WORD_WIDTH: stay IDLE, distance_error=1 for cycle N+1 only, no outputs produced.
- RUN, word_valid&word_ready at an edge:
  - if word_last: go to IDLE, word_valid=0, base_ready=1 from the next cycle. There is exactly one idle bubble between spheres.
  - else: mask = next larger integer with the same popcount (Gosper successor). The divide step must be a shift by the trailing-zero count of the lowest set bit; no dividers.
  - on the successor edge, update word_out and word_mask, and set word_last when the new mask equals the top-D-ones pattern.
- RUN, word_valid=1 and word_ready=0: hold word_out, word_mask and word_last stable (ready/valid rule). word_valid must not drop without a transfer.
- Output count per sphere: exactly C(WORD_WIDTH, D). D=0 yields one output equal to base_word with mask 0.
- Successor arithmetic is carried at WORD_WIDTH+1 bits so overflow past the top bit never aliases. word_last is the sole termination condition.
- base_valid in RUN is ignored (base_ready=0); the request is not captured.
- Output values are independent of base_word changes after acceptance.

Test Plan:
- WORD_WIDTH=4, base 4'b0000, D=2, word_ready=1 → masks 0011, 0101, 0110, 1001, 1010, 1100 on consecutive cycles; word_last only on 1100; base_ready=1 one cycle after that.
- WORD_WIDTH=4, base 4'b1010, D=1 → word_out 1011, 1000, 1110, 0010; 4 outputs; last on 0010.
- WORD_WIDTH=8, D=0 → single output equal to base with word_last=1. D=8 on base 8'h0F → single output 8'hF0, last.
- WORD_WIDTH=4, D=5 → distance_error high exactly one cycle; word_valid stays 0; base_ready stays 1.
- WORD_WIDTH=4, D=2 with random word_ready stalls → outputs held stable during stalls; the same 6-mask sequence is produced with no duplicates or skips.
- Assert clear_n low after the third output of a D=2 sphere → word_valid=0 and all outputs 0 immediately. After release, a new request with D=1 starts fresh at mask 0001.

Source files
------------

// File: rtl/hamming_sphere_generator_if.sv
// Request/response channels of the Hamming sphere generator.
// The slave modport is the generator's view; master is the requester/consumer view.
interface hamming_sphere_generator_if #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned DIST_WIDTH = WORD_WIDTH
);
  logic                  base_valid;
  logic                  base_ready;
  logic [WORD_WIDTH-1:0] base_word;
  logic [DIST_WIDTH-1:0] base_distance;
  logic                  word_valid;
  logic                  word_ready;
  logic [WORD_WIDTH-1:0] word_out;
  logic [WORD_WIDTH-1:0] word_mask;
  logic                  word_last;
  logic                  distance_error;

  modport slave (
    input  base_valid, base_word, base_distance, word_ready,
    output base_ready, word_valid, word_out, word_mask, word_last, distance_error
  );

  modport master (
    output base_valid, base_word, base_distance, word_ready,
    input  base_ready, word_valid, word_out, word_mask, word_last, distance_error
  );
endinterface

// File: rtl/hamming_sphere_generator.sv
// Enumerates every word at exactly Hamming distance D from a base word.
// Masks with D ones are walked in increasing numeric order using the
// Gosper successor; the top-D-ones mask marks the final output.
module hamming_sphere_generator #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned DIST_WIDTH = WORD_WIDTH
) (
  input logic                        clock,
  input logic                        clear_n,
  hamming_sphere_generator_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int unsigned TZW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int unsigned EW  = DIST_WIDTH + 1;
  localparam logic [EW-1:0] W_EXT = EW'(WORD_WIDTH);

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] base_q, base_d;
  logic [WORD_WIDTH-1:0] mask_q, mask_d;
  logic [WORD_WIDTH-1:0] top_q, top_d;
  logic [WORD_WIDTH-1:0] out_q, out_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic [EW-1:0]         dist_ext;
  logic                  dist_bad;
  logic [WORD_WIDTH-1:0] low_mask;
  logic [WORD_WIDTH-1:0] top_mask;

  logic [WORD_WIDTH:0]   mask_x;
  logic [WORD_WIDTH:0]   lowbit;
  logic [WORD_WIDTH:0]   ripple;
  logic [WORD_WIDTH:0]   succ_x;
  logic [TZW-1:0]        tz;
  logic                  tz_found;

  // Decode an incoming request: range check, first mask and final mask.
  always_comb begin
    dist_ext = {1'b0, bus.base_distance};
    dist_bad = (dist_ext > W_EXT);
    low_mask = '0;
    top_mask = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      low_mask[i] = (EW'(i) < dist_ext);
    end
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      top_mask[WORD_WIDTH-1-i] = low_mask[i];
    end
  end

  // Gosper successor at WORD_WIDTH+1 bits; division by the lowest set bit
  // is replaced by a right shift of its trailing-zero count.
  always_comb begin
    mask_x   = {1'b0, mask_q};
    lowbit   = mask_x & (~mask_x + 1'b1);
    ripple   = mask_x + lowbit;
    tz       = '0;
    tz_found = 1'b0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      if (!tz_found && mask_q[i]) begin
        tz       = TZW'(i);
        tz_found = 1'b1;
      end
    end
    succ_x = (((ripple ^ mask_x) >> 2) >> tz) | ripple;
  end

  // Next-state and next-output logic for the IDLE/RUN controller.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mask_d  = mask_q;
    top_d   = top_q;
    out_d   = out_q;
    last_d  = last_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.base_valid) begin
          if (dist_bad) begin
            err_d = 1'b1;
          end else begin
            base_d  = bus.base_word;
            mask_d  = low_mask;
            top_d   = top_mask;
            out_d   = bus.base_word ^ low_mask;
            last_d  = (low_mask == top_mask);
            valid_d = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (valid_q && bus.word_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            mask_d = succ_x[WORD_WIDTH-1:0];
            out_d  = base_q ^ succ_x[WORD_WIDTH-1:0];
            last_d = (succ_x == {1'b0, top_q});
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; clear_n abandons any sphere immediately.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      mask_q  <= '0;
      top_q   <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      top_q   <= top_d;
      out_q   <= out_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.base_ready     = (state_q == IDLE);
  assign bus.word_valid     = valid_q;
  assign bus.word_out       = out_q;
  assign bus.word_mask      = mask_q;
  assign bus.word_last      = last_q;
  assign bus.distance_error = err_q;

endmodule
